// File: rtl/led_pattern_ctrl_if.sv
// Pin-side bundle of the LED pattern controller: raw button in, LED/mode/pulse outputs.
// The master side drives the button; the slave side is the controller.
interface led_pattern_ctrl_if #(
    parameter int unsigned NUM_LEDS = 4
);
    logic                btn_n;
    logic [NUM_LEDS-1:0] led;
    logic [1:0]          mode;
    logic                btn_pressed;
    logic                tick;

    modport master (
        output btn_n,
        input  led,
        input  mode,
        input  btn_pressed,
        input  tick
    );

    modport slave (
        input  btn_n,
        output led,
        output mode,
        output btn_pressed,
        output tick
    );
endinterface

// File: rtl/led_pattern_ctrl.sv
// Multi-LED pattern controller: STATIC/BLINK/CHASE/BREATHE modes stepped by a debounced
// button press; a held button forces every LED on while the patterns keep running.
module led_pattern_ctrl #(
    parameter int unsigned NUM_LEDS       = 4,
    parameter int unsigned TICK_DIV       = 12090,
    parameter int unsigned BLINK_TICKS    = 820,
    parameter int unsigned DEBOUNCE_TICKS = 20,
    parameter int unsigned PWM_BITS       = 8
) (
    input logic               clk,
    input logic               rst,
    led_pattern_ctrl_if.slave bus
);
    localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned StepW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam int unsigned DbW   = $clog2(DEBOUNCE_TICKS + 1);

    localparam logic [TickW-1:0]    TickLast = TickW'(TICK_DIV - 1);
    localparam logic [StepW-1:0]    StepLast = StepW'(BLINK_TICKS - 1);
    localparam logic [DbW-1:0]      DbLimit  = DbW'(DEBOUNCE_TICKS);
    localparam logic [PWM_BITS-1:0] DutyMax  = '1;

    typedef enum logic [1:0] {
        ModeStatic  = 2'd0,
        ModeBlink   = 2'd1,
        ModeChase   = 2'd2,
        ModeBreathe = 2'd3
    } mode_e;

    logic [TickW-1:0]    tick_cnt_q, tick_cnt_d;
    logic [1:0]          sync_q;
    logic                db_pressed_q, db_pressed_d;
    logic [DbW-1:0]      db_cnt_q, db_cnt_d;
    mode_e               mode_q, mode_d;
    logic [StepW-1:0]    step_cnt_q, step_cnt_d;
    logic                blink_q, blink_d;
    logic [NUM_LEDS-1:0] chase_q, chase_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic                duty_up_q, duty_up_d;
    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic [NUM_LEDS-1:0] led_q, led_d;
    logic                btn_pressed_q;

    logic tick_ev, step_ev, press_ev, sync_pressed;

    assign tick_ev      = (tick_cnt_q == TickLast);
    assign step_ev      = tick_ev && (step_cnt_q == StepLast);
    assign sync_pressed = ~sync_q[1];
    assign tick_cnt_d   = tick_ev ? '0 : tick_cnt_q + TickW'(1);

    // Debounce: the synced level must disagree for DEBOUNCE_TICKS consecutive ticks.
    always_comb begin
        db_cnt_d     = db_cnt_q;
        db_pressed_d = db_pressed_q;
        press_ev     = 1'b0;
        if (tick_ev) begin
            if (sync_pressed != db_pressed_q) begin
                if (db_cnt_q + DbW'(1) == DbLimit) begin
                    db_cnt_d     = '0;
                    db_pressed_d = sync_pressed;
                    press_ev     = sync_pressed;
                end else begin
                    db_cnt_d = db_cnt_q + DbW'(1);
                end
            end else begin
                db_cnt_d = '0;
            end
        end
    end

    // A press takes priority: any coincident step or duty update is dropped.
    always_comb begin
        mode_d     = mode_q;
        step_cnt_d = step_cnt_q;
        blink_d    = blink_q;
        chase_d    = chase_q;
        duty_d     = duty_q;
        duty_up_d  = duty_up_q;
        if (press_ev) begin
            mode_d     = mode_e'(mode_q + 2'd1);
            step_cnt_d = '0;
            blink_d    = 1'b0;
            chase_d    = NUM_LEDS'(1);
            duty_d     = '0;
            duty_up_d  = 1'b1;
        end else if (tick_ev) begin
            step_cnt_d = step_ev ? '0 : step_cnt_q + StepW'(1);
            if (step_ev) begin
                blink_d = ~blink_q;
                chase_d = {chase_q[NUM_LEDS-2:0], chase_q[NUM_LEDS-1]};
            end
            if (duty_up_q) begin
                if (duty_q == DutyMax) begin
                    duty_up_d = 1'b0;
                    duty_d    = duty_q - PWM_BITS'(1);
                end else begin
                    duty_d = duty_q + PWM_BITS'(1);
                end
            end else begin
                if (duty_q == '0) begin
                    duty_up_d = 1'b1;
                    duty_d    = PWM_BITS'(1);
                end else begin
                    duty_d = duty_q - PWM_BITS'(1);
                end
            end
        end
    end

    always_comb begin
        led_d = '0;
        unique case (mode_q)
            ModeStatic:  led_d = '1;
            ModeBlink:   led_d = {NUM_LEDS{blink_q}};
            ModeChase:   led_d = chase_q;
            ModeBreathe: led_d = {NUM_LEDS{pwm_cnt_q < duty_q}};
            default:     led_d = '0;
        endcase
        if (db_pressed_q) begin
            led_d = '1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt_q    <= '0;
            sync_q        <= 2'b11;
            db_pressed_q  <= 1'b0;
            db_cnt_q      <= '0;
            mode_q        <= ModeBlink;
            step_cnt_q    <= '0;
            blink_q       <= 1'b0;
            chase_q       <= NUM_LEDS'(1);
            duty_q        <= '0;
            duty_up_q     <= 1'b1;
            pwm_cnt_q     <= '0;
            led_q         <= '0;
            btn_pressed_q <= 1'b0;
        end else begin
            tick_cnt_q    <= tick_cnt_d;
            sync_q        <= {sync_q[0], bus.btn_n};
            db_pressed_q  <= db_pressed_d;
            db_cnt_q      <= db_cnt_d;
            mode_q        <= mode_d;
            step_cnt_q    <= step_cnt_d;
            blink_q       <= blink_d;
            chase_q       <= chase_d;
            duty_q        <= duty_d;
            duty_up_q     <= duty_up_d;
            pwm_cnt_q     <= pwm_cnt_q + PWM_BITS'(1);
            led_q         <= led_d;
            btn_pressed_q <= press_ev;
        end
    end

    assign bus.led         = led_q;
    assign bus.mode        = mode_q;
    assign bus.btn_pressed = btn_pressed_q;
    assign bus.tick        = tick_ev;
endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Randomised directed bench for led_pattern_ctrl against an integer-level reference model.
module tb_led_pattern_ctrl;
    localparam int N    = 4;
    localparam int TD   = 4;
    localparam int BT   = 3;
    localparam int DB   = 2;
    localparam int PB   = 3;
    localparam int MAXD = (1 << PB) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    int   pulses = 0;
    int   p0;

    led_pattern_ctrl_if #(.NUM_LEDS(N)) bus ();

    led_pattern_ctrl #(
        .NUM_LEDS      (N),
        .TICK_DIV      (TD),
        .BLINK_TICKS   (BT),
        .DEBOUNCE_TICKS(DB),
        .PWM_BITS      (PB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Reference model: plain integers, chase kept as a lit-LED index, breathe as a phase.
    int m_tcnt, m_s1, m_s2, m_dbp, m_dbc, m_mode, m_scnt, m_blink, m_idx, m_ph, m_pwm;
    logic [N-1:0] m_led;
    logic         m_pressed;

    function automatic int duty_of(input int ph);
        return (ph <= MAXD) ? ph : 2 * MAXD - ph;
    endfunction

    function automatic logic [N-1:0] pattern_now();
        case (m_mode)
            0:       return {N{1'b1}};
            1:       return {N{m_blink[0]}};
            2:       return N'(1 << m_idx);
            default: return {N{m_pwm < duty_of(m_ph)}};
        endcase
    endfunction

    task automatic model_reset();
        m_tcnt = 0; m_s1 = 1; m_s2 = 1; m_dbp = 0; m_dbc = 0; m_mode = 1;
        m_scnt = 0; m_blink = 0; m_idx = 0; m_ph = 0; m_pwm = 0;
        m_led = '0; m_pressed = 1'b0;
    endtask

    task automatic model_edge(input logic btn);
        bit tick_now, press;
        tick_now  = (m_tcnt == TD - 1);
        m_led     = m_dbp ? {N{1'b1}} : pattern_now();
        press     = 0;
        if (tick_now) begin
            if ((m_s2 == 0 ? 1 : 0) != m_dbp) begin
                m_dbc++;
                if (m_dbc == DB) begin
                    m_dbc = 0;
                    m_dbp = 1 - m_dbp;
                    press = (m_dbp == 1);
                end
            end else begin
                m_dbc = 0;
            end
        end
        m_pressed = press;
        if (press) begin
            m_mode = (m_mode + 1) % 4;
            m_scnt = 0; m_blink = 0; m_idx = 0; m_ph = 0;
        end else if (tick_now) begin
            m_scnt++;
            if (m_scnt == BT) begin
                m_scnt  = 0;
                m_blink = 1 - m_blink;
                m_idx   = (m_idx + 1) % N;
            end
            m_ph = (m_ph + 1) % (2 * MAXD);
        end
        m_pwm  = (m_pwm + 1) % (1 << PB);
        m_tcnt = (m_tcnt + 1) % TD;
        m_s2   = m_s1;
        m_s1   = btn;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("led", 8'(bus.led), 8'(m_led));
        chk("mode", 8'(bus.mode), 8'(m_mode));
        chk("btn_pressed", 8'(bus.btn_pressed), 8'(m_pressed));
        chk("tick", 8'(bus.tick), 8'(m_tcnt == TD - 1));
        if (bus.btn_pressed === 1'b1) pulses++;
    endtask

    task automatic run(input int n, input logic b);
        for (int i = 0; i < n; i++) begin
            bus.btn_n = b;
            @(posedge clk);
            model_edge(b);
            @(negedge clk);
            check_all();
        end
    endtask

    task automatic press_once();
        run(DB * TD + 3 + $urandom_range(0, 12), 1'b0);
        run(DB * TD + 3 + $urandom_range(4, 12), 1'b1);
    endtask

    initial begin
        bus.btn_n = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all();
        rst = 1'b0;

        // Idle BLINK: tick period and blink toggling.
        run(40 + $urandom_range(0, 8), 1'b1);

        // One long press -> CHASE, LEDs forced on while held.
        p0 = pulses;
        run(DB * TD + 3, 1'b0);
        chk("held_led", 8'(bus.led), 8'hF);
        run($urandom_range(0, 10), 1'b0);
        run(DB * TD + 3, 1'b1);
        chk("press_pulses", 8'(pulses - p0), 8'd1);
        chk("mode_chase", 8'(bus.mode), 8'd2);
        run(50, 1'b1);
        chk("chase_onehot", 8'($onehot(bus.led)), 8'd1);

        // Short glitches never get through the debouncer.
        p0 = pulses;
        for (int g = 0; g < 5; g++) begin
            run($urandom_range(1, TD), 1'b0);
            run($urandom_range(2 * TD, 4 * TD), 1'b1);
        end
        chk("glitch_pulses", 8'(pulses - p0), 8'd0);
        chk("glitch_mode", 8'(bus.mode), 8'd2);

        // Mode wrap 2 -> 3 -> 0 -> 1, STATIC holds all on.
        press_once();
        chk("mode_seq3", 8'(bus.mode), 8'd3);
        press_once();
        chk("mode_seq0", 8'(bus.mode), 8'd0);
        run(20, 1'b1);
        chk("static_led", 8'(bus.led), 8'hF);
        press_once();
        chk("mode_seq1", 8'(bus.mode), 8'd1);

        // BREATHE over more than one full ramp.
        press_once();
        press_once();
        chk("mode_breathe", 8'(bus.mode), 8'd3);
        run(2 * 2 * MAXD * TD + $urandom_range(0, 20), 1'b1);

        // Into CHASE, start a press, reset it halfway through debouncing.
        press_once();
        press_once();
        press_once();
        chk("mode_chase2", 8'(bus.mode), 8'd2);
        run($urandom_range(5, 20), 1'b1);
        run(TD + 2, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("rst_led", 8'(bus.led), 8'h0);
        chk("rst_mode", 8'(bus.mode), 8'd1);
        chk("rst_pulse", 8'(bus.btn_pressed), 8'd0);
        chk("rst_tick", 8'(bus.tick), 8'd0);
        model_reset();
        bus.btn_n = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all();
        rst = 1'b0;
        p0 = pulses;
        run(40, 1'b1);
        chk("post_rst_pulses", 8'(pulses - p0), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
